// File: rtl/ps2_rx_ctrl.sv
// ps2_rx_ctrl: PS/2 keyboard frame receiver.
//   Synchronises ps2_clk/ps2_data, glitch-filters ps2_clk and converts each
//   filtered falling edge into a one-cycle sample strobe. A small FSM collects
//   start, 8 data bits (LSB first), odd parity and stop, validates the frame
//   and hands the byte downstream over a valid/ready handshake.
//
// Optional feature: define PS2_RX_TIMEOUT_EN to abort a frame (frame_err
// pulse) when no strobe arrives for TIMEOUT_CYCLES-1 cycles while receiving.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous reset, active-high
//   ps2_clk    raw PS/2 clock pin (asynchronous)
//   ps2_data   raw PS/2 data pin (asynchronous)
//   en         receive enable; 0 holds the FSM in IDLE
//   rx_data    received byte, stable while rx_valid=1
//   rx_valid   byte available, held until accepted
//   rx_ready   consumer accepts when rx_valid & rx_ready
//   frame_err  1-cycle pulse on bad start/parity/stop or timeout
//   overrun    1-cycle pulse when a good frame is dropped (rx_valid pending)
//   busy       1 while the FSM is not IDLE
//   num        bits received in the current frame (0..10)
//
// State  | meaning
// IDLE   | waiting for a start bit (strobe with data=0)
// RECV   | shifting data, parity and stop bits into sh
// CHECK  | one cycle: validate frame, deliver byte or flag error/overrun

module ps2_rx_ctrl #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       en,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy,
    output logic [3:0] num
);

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [FW-1:0] FILT_LOAD = FW'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_s;
    logic                   data_s;
    logic                   filt_clk;
    logic [FW-1:0]          filt_cnt;
    logic                   strobe;
    logic                   strobe_bit;
    logic                   to_tc;

    state_t     state, state_n;
    logic [9:0] sh, sh_n;
    logic [3:0] num_n;
    logic [7:0] rx_data_n;
    logic       rx_valid_n;
    logic       frame_err_n;
    logic       overrun_n;

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
        end
    end

    // Down-counter runs while the synced level differs from the filtered one;
    // terminal count on the FILTER_LEN-th differing sample flips the level.
    // The strobe and its data bit are registered on that same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_clk   <= 1'b1;
            filt_cnt   <= FILT_LOAD;
            strobe     <= 1'b0;
            strobe_bit <= 1'b1;
        end else begin
            strobe <= 1'b0;
            if (clk_s == filt_clk) begin
                filt_cnt <= FILT_LOAD;
            end else if (filt_cnt == '0) begin
                filt_clk <= clk_s;
                filt_cnt <= FILT_LOAD;
                if (!clk_s) begin
                    strobe     <= 1'b1;
                    strobe_bit <= data_s;
                end
            end else begin
                filt_cnt <= filt_cnt - 1'b1;
            end
        end
    end

`ifdef PS2_RX_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] to_cnt;

    // Reloaded outside RECV and on every strobe, so it only measures the gap
    // since the last strobe of the frame in progress.
    always_ff @(posedge clk) begin
        if (reset || (state != RECV) || strobe) begin
            to_cnt <= TO_LOAD;
        end else if (to_cnt != '0) begin
            to_cnt <= to_cnt - 1'b1;
        end
    end

    assign to_tc = (state == RECV) && (to_cnt == '0);
`else
    assign to_tc = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sh        <= '0;
            num       <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            sh        <= sh_n;
            num       <= num_n;
            rx_data   <= rx_data_n;
            rx_valid  <= rx_valid_n;
            frame_err <= frame_err_n;
            overrun   <= overrun_n;
        end
    end

    always_comb begin
        state_n     = state;
        sh_n        = sh;
        num_n       = num;
        rx_data_n   = rx_data;
        rx_valid_n  = rx_valid & ~rx_ready;
        frame_err_n = 1'b0;
        overrun_n   = 1'b0;

        unique case (state)
            IDLE: begin
                num_n = '0;
                if (strobe && !strobe_bit && en) begin
                    state_n = RECV;
                    num_n   = 4'd1;
                end
            end

            RECV: begin
                if (!en) begin
                    state_n = IDLE;
                    num_n   = '0;
                end else if (strobe) begin
                    sh_n = {strobe_bit, sh[9:1]};
                    // num reaches 10 on the parity bit and saturates there;
                    // the strobe arriving at num=10 is the stop bit.
                    if (num == 4'd10) begin
                        state_n = CHECK;
                    end else begin
                        num_n = num + 4'd1;
                    end
                end else if (to_tc) begin
                    state_n     = IDLE;
                    num_n       = '0;
                    frame_err_n = 1'b1;
                end
            end

            CHECK: begin
                state_n = IDLE;
                num_n   = '0;
                if (!(^sh[8:0]) || !sh[9]) begin
                    frame_err_n = 1'b1;
                end else if (!rx_valid || rx_ready) begin
                    rx_data_n  = sh[7:0];
                    rx_valid_n = 1'b1;
                end else begin
                    overrun_n = 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
                num_n   = '0;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
module tb_ps2_rx_ctrl;

    localparam int SYNC_STAGES = 2;
    localparam int FILTER_LEN  = 4;
    localparam int TIMEOUT     = 300;
    localparam int HALF        = 10;   // ps2_clk high time in clk cycles
    localparam int LOW         = 10;   // ps2_clk low time in clk cycles
    localparam int GAP         = 20;
    // posedges from driving ps2_clk low to the CHECK cycle:
    // sync stages + filter samples + registered strobe
    localparam int LAT         = SYNC_STAGES + FILTER_LEN + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       en = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       frame_err;
    logic       overrun;
    logic       busy;
    logic [3:0] num;

    ps2_rx_ctrl #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .en       (en),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy),
        .num      (num)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] exp_q[$];
    int         exp_err = 0;
    int         exp_ov  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ps2_bit(input logic b, input int low);
        ps2_data = b;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(low);
        ps2_clk = 1'b1;
    endtask

    function automatic logic [10:0] mk(input logic [7:0] d, input logic p, input logic s);
        return {s, p, d, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int first, input int last);
        for (int i = first; i <= last; i++) ps2_bit(f[i], LOW);
    endtask

    task automatic accept();
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    // Monitor / scoreboard
    logic       rv_p = 1'b0, rdy_p = 1'b0, fe_p = 1'b0, ov_p = 1'b0, rst_p = 1'b1;
    logic [7:0] d_p = '0;

    always @(negedge clk) begin
        if (!reset && !rst_p) begin
            if (rv_p && !rdy_p) begin
                check("hold_valid", rx_valid, 1);
                check("hold_data", rx_data, d_p);
            end
            if (rx_valid && rx_ready) begin
                check("accept_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("rx_data", rx_data, exp_q.pop_front());
            end
            if (frame_err) begin
                check("frame_err_expected", exp_err > 0, 1);
                if (exp_err > 0) exp_err--;
                check("frame_err_width", fe_p, 0);
            end
            if (overrun) begin
                check("overrun_expected", exp_ov > 0, 1);
                if (exp_ov > 0) exp_ov--;
                check("overrun_width", ov_p, 0);
            end
        end
        rv_p  = rx_valid;
        rdy_p = rx_ready;
        fe_p  = frame_err;
        ov_p  = overrun;
        rst_p = reset;
        d_p   = rx_data;
    end

    initial begin
        logic [10:0] f;

        tick(5);
        reset = 1'b0;
        tick(2);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        check("rst_num", num, 0);

        // 1: good 0x1C, latency and hold, then one-cycle accept
        f = mk(8'h1C, 1'b0, 1'b1);
        send_bits(f, 0, 9);
        check("t1_num_sat", num, 10);
        ps2_data = 1'b1;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(LAT);
        check("t1_check_busy", busy, 1);
        check("t1_valid_early", rx_valid, 0);
        tick(1);
        check("t1_valid_lat", rx_valid, 1);
        check("t1_data", rx_data, 8'h1C);
        check("t1_busy_after", busy, 0);
        check("t1_num_after", num, 0);
        tick(LOW - LAT - 1);
        ps2_clk = 1'b1;
        tick(GAP);
        check("t1_still_valid", rx_valid, 1);
        exp_q.push_back(8'h1C);
        accept();
        check("t1_valid_clear", rx_valid, 0);

        // 2: 0xF0 with wrong parity
        exp_err++;
        send_bits(mk(8'hF0, 1'b0, 1'b1), 0, 10);
        tick(GAP);
        check("t2_valid", rx_valid, 0);
        check("t2_busy", busy, 0);

        // 3: overrun, then accept in the CHECK cycle of a repeated frame
        send_bits(mk(8'h1C, 1'b0, 1'b1), 0, 10);
        tick(GAP);
        exp_ov++;
        send_bits(mk(8'h32, 1'b0, 1'b1), 0, 10);
        tick(GAP);
        check("t3_kept_valid", rx_valid, 1);
        check("t3_kept_data", rx_data, 8'h1C);
        f = mk(8'h32, 1'b0, 1'b1);
        send_bits(f, 0, 9);
        ps2_data = 1'b1;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(LAT);
        exp_q.push_back(8'h1C);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        check("t3_reload_valid", rx_valid, 1);
        check("t3_reload_data", rx_data, 8'h32);
        tick(LOW - LAT - 1);
        ps2_clk = 1'b1;
        tick(GAP);
        exp_q.push_back(8'h32);
        accept();
        check("t3_valid_clear", rx_valid, 0);

        // 4: bad stop bit
        exp_err++;
        send_bits(mk(8'h1C, 1'b0, 1'b0), 0, 10);
        tick(GAP);
        check("t4_valid", rx_valid, 0);
        check("t4_busy", busy, 0);

        // 5: glitches mid-frame; a 4-cycle low is a real strobe
        rx_ready = 1'b1;
        exp_q.push_back(8'hA5);
        f = mk(8'hA5, 1'b1, 1'b1);
        send_bits(f, 0, 2);
        tick(2);
        check("t5_num_before", num, 3);
        ps2_clk = 1'b0;
        tick(1);
        ps2_clk = 1'b1;
        tick(12);
        check("t5_num_glitch1", num, 3);
        ps2_clk = 1'b0;
        tick(3);
        ps2_clk = 1'b1;
        tick(12);
        check("t5_num_glitch3", num, 3);
        ps2_bit(f[3], FILTER_LEN);
        tick(6);
        check("t5_num_low4", num, 4);
        send_bits(f, 4, 10);
        tick(GAP);
        rx_ready = 1'b0;
        check("t5_valid_clear", rx_valid, 0);

        // 6: stalled frame, then reset
        send_bits(mk(8'h1C, 1'b0, 1'b1), 0, 3);
        tick(GAP);
        check("t6_busy_mid", busy, 1);
        check("t6_num_mid", num, 4);
`ifdef PS2_RX_TIMEOUT_EN
        exp_err++;
        tick(TIMEOUT + 20);
        check("t6_busy_to", busy, 0);
        check("t6_num_to", num, 0);
`else
        tick(TIMEOUT + 20);
        check("t6_busy_wait", busy, 1);
        check("t6_num_wait", num, 4);
`endif
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
        check("t6_busy_rst", busy, 0);
        check("t6_num_rst", num, 0);
        check("t6_err_rst", frame_err, 0);

        // 7: en dropped mid-frame returns to IDLE silently
        send_bits(mk(8'h1C, 1'b0, 1'b1), 0, 2);
        tick(2);
        check("t7_busy_mid", busy, 1);
        en = 1'b0;
        tick(2);
        check("t7_busy_off", busy, 0);
        check("t7_num_off", num, 0);
        tick(GAP);

        check("end_queue_empty", exp_q.size(), 0);
        check("end_err_pending", exp_err, 0);
        check("end_ov_pending", exp_ov, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
